// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - timed WHITE/GREEN/YELLOW/RED phase sequencer with 1 s prescaler (optional PED_REQ_EN)

// Shared colour codes. The def.v definitions take precedence when that file is compiled first.
`ifndef WHITE
`define WHITE  2'b00
`endif
`ifndef RED
`define RED    2'b01
`endif
`ifndef GREEN
`define GREEN  2'b10
`endif
`ifndef YELLOW
`define YELLOW 2'b11
`endif

module traffic_light_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int INIT_SEC      = 1,
  parameter int GREEN_SEC     = 5,
  parameter int YELLOW_SEC    = 2,
  parameter int RED_SEC       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
`ifdef PED_REQ_EN
  input  logic       ped_req_i,
`endif
  output logic [1:0] color_o,
  output logic [7:0] remain_o,
  output logic       sec_tick_o
);

  localparam int            PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    INIT_DUR   = 8'(INIT_SEC);
  localparam logic [7:0]    GREEN_DUR  = 8'(GREEN_SEC);
  localparam logic [7:0]    YELLOW_DUR = 8'(YELLOW_SEC);
  localparam logic [7:0]    RED_DUR    = 8'(RED_SEC);

  typedef enum logic [1:0] {S_INIT, S_GREEN, S_YELLOW, S_RED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    remain_q, remain_d;
  logic [1:0]    color_q, color_d;
  logic          tick_q, tick_d;
  logic          wrap;
`ifdef PED_REQ_EN
  logic          ped_q, ped_d;
  logic          ped_hit;
`endif

  // Prescaler: wrap marks the last enabled cycle of a second; the tick flag is
  // held while disabled so a pulse is shown on the first enabled cycle instead of lost.
  always_comb begin
    wrap    = en_i && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    tick_d  = tick_q;
    if (en_i) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
      tick_d  = wrap;
    end
  end

  // Phase FSM: count down on each second, switch phase and colour together on the last one.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    color_d  = color_q;
`ifdef PED_REQ_EN
    ped_d    = ped_q;
    ped_hit  = ped_q || ped_req_i;
    if (state_q == S_GREEN && ped_req_i) ped_d = 1'b1;
`endif
    if (wrap) begin
      if (remain_q > 8'd1) begin
        remain_d = remain_q - 8'd1;
`ifdef PED_REQ_EN
        if (state_q == S_GREEN && ped_hit && remain_q > 8'd2) remain_d = 8'd2;
`endif
      end else begin
        case (state_q)
          S_INIT: begin
            state_d  = S_GREEN;
            remain_d = GREEN_DUR;
            color_d  = `GREEN;
          end
          S_GREEN: begin
            state_d  = S_YELLOW;
            remain_d = YELLOW_DUR;
            color_d  = `YELLOW;
`ifdef PED_REQ_EN
            ped_d    = 1'b0;
`endif
          end
          S_YELLOW: begin
            state_d  = S_RED;
            remain_d = RED_DUR;
            color_d  = `RED;
          end
          S_RED: begin
            state_d  = S_GREEN;
            remain_d = GREEN_DUR;
            color_d  = `GREEN;
          end
          default: begin
            state_d  = S_INIT;
            remain_d = INIT_DUR;
            color_d  = `WHITE;
          end
        endcase
      end
    end
  end

  // State registers; reset restarts the lamp test immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_INIT;
      presc_q  <= '0;
      remain_q <= INIT_DUR;
      color_q  <= `WHITE;
      tick_q   <= 1'b0;
`ifdef PED_REQ_EN
      ped_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      color_q  <= color_d;
      tick_q   <= tick_d;
`ifdef PED_REQ_EN
      ped_q    <= ped_d;
`endif
    end
  end

  assign color_o    = color_q;
  assign remain_o   = remain_q;
  assign sec_tick_o = tick_q && en_i;

endmodule
